mlp_axil_slave: RTL and testbench
=================================

Name: mlp_axil_slave

Overview:
- AXI4-Lite responder (slave) register front-end for the cyMlp accelerator.
- Decodes host reads and writes into control, status and result registers.
- Captures the classifier result from the MLP output stage, raises intr, and issues a soft-reset pulse to the datapath.
- Sits between the host or CPU AXI-Lite bus and the network core. It is the bus end that the system test bench's writeAxi/readAxi tasks drive.

Parameters:
- ADDR_WIDTH, 5, byte address width; 8 word registers.
- DATA_WIDTH, 32, AXI data width.
- RESULT_WIDTH, `dataWidth (16), width of the classifier result from the core.
- SOFT_RST_CYCLES, 4, length of the soft_reset pulse in clocks.

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake.
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write response.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read-address handshake.
- s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1  read data.
- result_in  in  RESULT_WIDTH  detected class from the final layer.
- result_valid  in  1  one-cycle strobe qualifying result_in.
- core_busy  in  1  core is processing a sample.
- soft_reset  out  1  datapath reset pulse, active-high.
- intr  out  1  level interrupt: result ready.

Behaviour:
- Reset values: all ready, valid and resp outputs 0; rdata 0; intr 0; soft_reset 0; CTRL=0x1; RESULT=0; COUNT=0; done=0; overrun=0.
- Register map, word aligned, awaddr[1:0] ignored:
  - 0x00 CTRL RW: bit0 intr_en; other bits read 0.
  - 0x04 STATUS RO: bit0 done, bit1 core_busy, bit2 overrun.
  - 0x08 RESULT RO: zero-extended result.
  - 0x0C COUNT RO: results captured, wraps 0xFFFFFFFF->0.
  - 0x1C SOFT_RST WO: any write starts the pulse; reads return 0.
  - 0x10-0x18: unmapped.
- Write channel:
  - AW and W are accepted independently. Each has a latch flag.
  - awready=!aw_lat&&!bvalid; wready=!w_lat&&!bvalid. This gives one-cycle ready pulses.
  - Cycle after both flags are set: register update applies (CTRL honours wstrb[0]); bvalid=1; flags clear.
  - bvalid holds until bready; no new AW/W accepted while bvalid=1.
  - bresp=OKAY for 0x00/0x1C; OKAY with no effect for writes to RO 0x04-0x0C; SLVERR(2'b10) for unmapped.
- Read channel:
  - arready=!rvalid.
  - Cycle after the AR handshake: rdata registered, rvalid=1, held stable until rready.
  - Unmapped: rdata=0, rresp=SLVERR.
  - Side effect of a RESULT read, at the AR handshake: done=0, overrun=0.
- Result capture:
  - On result_valid: RESULT<=result_in, done<=1, COUNT+1.
  - If done was already 1: overrun<=1.
  - result_valid in the same cycle as the RESULT-read clear: capture wins (done=1); overrun is cleared.
  - rdata already returned holds the old value.
- intr:
  - Registered intr=done&intr_en, so intr rises 1 cycle after the result_valid edge.
  - Falls 1 cycle after the RESULT AR handshake, or after a CTRL write with bit0=0.
- Soft reset:
  - SOFT_RST write asserts soft_reset for exactly SOFT_RST_CYCLES cycles, starting the cycle bvalid rises.
  - Also clears done, overrun, RESULT, COUNT; CTRL is preserved.
  - A new SOFT_RST write during the pulse restarts the counter.
  - result_valid during the pulse is ignored.
- Async reset mid-transaction: all channels drop immediately; no response is issued for the aborted transfer.

Decomposition:
- Shared package/include: register offsets (CTRL, STATUS, RESULT, COUNT, SOFT_RST), RESP_OKAY/RESP_SLVERR, STATUS bit indices; RESULT_WIDTH from the existing `dataWidth define.
- One sub-module: mlp_axil_wr_chan (AW/W latching, B response), instantiated once. Read path, registers and pulse generator stay in the top.

Test Plan:
- Reset, then read 0x04 with core_busy=0 -> rdata=0, rresp=0, intr=0; read 0x00 -> 0x1.
- Write 0x1C data 0 with AW and W together -> wready high exactly 1 cycle; bvalid next cycle, bresp=0; soft_reset high 4 cycles.
- result_valid with result_in=7 -> intr=1 next cycle; read 0x08 -> rdata=7; intr=0 cycle after AR; read 0x0C -> 1.
- Two result_valid strobes (3, then 5) with no read between -> STATUS=0x5; RESULT=5; read 0x08 -> STATUS becomes 0x0.
- W presented 3 cycles before AW, then bready held low 5 cycles -> single write commits; bvalid stays high 5 cycles; the next AW is not accepted until after B completes.
- Read 0x14 -> rresp=2'b10, rdata=0; write 0x00 data 0 then result_valid -> done=1, intr stays 0.

Source files
------------

// File: rtl/mlp_axil_slave_pkg.sv
// Shared register map, response codes and STATUS bit positions for the cyMlp AXI-Lite front-end.
`ifndef dataWidth
`define dataWidth 16
`endif

package mlp_axil_slave_pkg;

  localparam int unsigned RESULT_W = `dataWidth;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_RESULT   = 3'd2,
    REG_COUNT    = 3'd3,
    REG_UNMAP4   = 3'd4,
    REG_UNMAP5   = 3'd5,
    REG_UNMAP6   = 3'd6,
    REG_SOFT_RST = 3'd7
  } reg_word_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STATUS_DONE    = 0;
  localparam int unsigned STATUS_BUSY    = 1;
  localparam int unsigned STATUS_OVERRUN = 2;

  function automatic reg_word_e word_of(input logic [2:0] word_addr);
    return reg_word_e'(word_addr);
  endfunction

  // Read-only registers accept writes silently; only the gap 0x10-0x18 errors.
  function automatic logic [1:0] wr_resp(input reg_word_e word);
    case (word)
      REG_UNMAP4, REG_UNMAP5, REG_UNMAP6: return RESP_SLVERR;
      default:                            return RESP_OKAY;
    endcase
  endfunction

endpackage

// File: rtl/mlp_axil_wr_chan.sv
// AXI-Lite write channel: independent AW/W latching, single-cycle commit strobe and B response.
module mlp_axil_wr_chan
  import mlp_axil_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [DATA_WIDTH/8-1:0] wr_strb_o
);

  logic                    aw_lat_q, aw_lat_d;
  logic                    w_lat_q, w_lat_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;

  always_comb begin
    awready_o = !aw_lat_q && !bvalid_q && !rst_i;
    wready_o  = !w_lat_q && !bvalid_q && !rst_i;
    wr_en_o   = aw_lat_q && w_lat_q;
    aw_lat_d  = aw_lat_q;
    w_lat_d   = w_lat_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (awvalid_i && awready_o) begin
      aw_lat_d = 1'b1;
      addr_d   = awaddr_i;
    end
    if (wvalid_i && wready_o) begin
      w_lat_d = 1'b1;
      data_d  = wdata_i;
      strb_d  = wstrb_i;
    end
    if (wr_en_o) begin
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = wr_resp(word_of(addr_q[4:2]));
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
    end else begin
      aw_lat_q <= aw_lat_d;
      w_lat_q  <= w_lat_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
    end
  end

  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign wr_strb_o = strb_q;

endmodule

// File: rtl/mlp_axil_slave.sv
// cyMlp AXI-Lite register front-end: control/status/result registers, result capture,
// level interrupt and datapath soft-reset pulse generator.
module mlp_axil_slave
  import mlp_axil_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RESULT_WIDTH    = RESULT_W,
  parameter int unsigned SOFT_RST_CYCLES = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [RESULT_WIDTH-1:0] result_in,
  input  logic                    result_valid,
  input  logic                    core_busy,
  output logic                    soft_reset,
  output logic                    intr
);

  localparam int unsigned CNT_W = $clog2(SOFT_RST_CYCLES + 1);

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;

  mlp_axil_wr_chan #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_chan (
    .clk_i     (s_axi_aclk),
    .rst_i     (s_axi_areset),
    .awaddr_i  (s_axi_awaddr),
    .awvalid_i (s_axi_awvalid),
    .awready_o (s_axi_awready),
    .wdata_i   (s_axi_wdata),
    .wstrb_i   (s_axi_wstrb),
    .wvalid_i  (s_axi_wvalid),
    .wready_o  (s_axi_wready),
    .bresp_o   (s_axi_bresp),
    .bvalid_o  (s_axi_bvalid),
    .bready_i  (s_axi_bready),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb)
  );

  logic                    ctrl_en_q, ctrl_en_d;
  logic                    done_q, done_d;
  logic                    ovr_q, ovr_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic                    intr_q, intr_d;
  logic [CNT_W-1:0]        srst_cnt_q, srst_cnt_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  reg_word_e               wr_word, rd_word;
  logic                    ar_hs, srst_start, pulse_on, capture, rd_clear;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_resp;

  always_comb begin
    wr_word       = word_of(wr_addr[4:2]);
    rd_word       = word_of(s_axi_araddr[4:2]);
    s_axi_arready = !rvalid_q && !s_axi_areset;
    ar_hs         = s_axi_arvalid && s_axi_arready;
    srst_start    = wr_en && (wr_word == REG_SOFT_RST);
    pulse_on      = (srst_cnt_q != '0);
    capture       = result_valid && !pulse_on;
    rd_clear      = ar_hs && (rd_word == REG_RESULT);

    ctrl_en_d  = ctrl_en_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    result_d   = result_q;
    count_d    = count_q;
    srst_cnt_d = srst_cnt_q;
    intr_d     = done_q && ctrl_en_q;

    if (wr_en && (wr_word == REG_CTRL) && wr_strb[0]) ctrl_en_d = wr_data[0];

    // Soft reset outranks a same-cycle capture; a capture outranks a RESULT-read clear
    // but the read still wipes the overrun history.
    if (srst_start) begin
      srst_cnt_d = CNT_W'(SOFT_RST_CYCLES);
      done_d     = 1'b0;
      ovr_d      = 1'b0;
      result_d   = '0;
      count_d    = '0;
    end else begin
      if (pulse_on) srst_cnt_d = srst_cnt_q - 1'b1;
      if (capture) begin
        result_d = result_in;
        done_d   = 1'b1;
        count_d  = count_q + 1'b1;
        ovr_d    = (ovr_q || done_q) && !rd_clear;
      end else if (rd_clear) begin
        done_d = 1'b0;
        ovr_d  = 1'b0;
      end
    end

    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_word)
      REG_CTRL:   rd_data[0] = ctrl_en_q;
      REG_STATUS: begin
        rd_data[STATUS_DONE]    = done_q;
        rd_data[STATUS_BUSY]    = core_busy;
        rd_data[STATUS_OVERRUN] = ovr_q;
      end
      REG_RESULT:   rd_data = DATA_WIDTH'(result_q);
      REG_COUNT:    rd_data = count_q;
      REG_SOFT_RST: rd_data = '0;
      default:      rd_resp = RESP_SLVERR;
    endcase

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      ctrl_en_q  <= 1'b1;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      result_q   <= '0;
      count_q    <= '0;
      intr_q     <= 1'b0;
      srst_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      result_q   <= result_d;
      count_q    <= count_d;
      intr_q     <= intr_d;
      srst_cnt_q <= srst_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign soft_reset   = pulse_on;
  assign intr         = intr_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], wr_addr[1:0],
                         wr_data[DATA_WIDTH-1:1], wr_strb[DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_mlp_axil_slave.sv
// Directed plus randomized bench for mlp_axil_slave against a register-level reference model.
module tb_mlp_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [15:0] result_in;
  logic        result_valid, core_busy, soft_reset, intr;

  always #5 clk = ~clk;

  mlp_axil_slave #(
    .ADDR_WIDTH      (5),
    .DATA_WIDTH      (32),
    .RESULT_WIDTH    (16),
    .SOFT_RST_CYCLES (4)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .result_in     (result_in),
    .result_valid  (result_valid),
    .core_busy     (core_busy),
    .soft_reset    (soft_reset),
    .intr          (intr)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference register state
  logic        m_en, m_done, m_ovr;
  logic [15:0] m_result;
  logic [31:0] m_count;

  // Bus-activity monitor
  int   run_len = 0, last_pulse = 0, w_hs = 0, b_rise = 0;
  logic prev_soft = 1'b0, prev_b = 1'b0, b_at_rise = 1'b0;

  always @(negedge clk) begin
    if (soft_reset) run_len++;
    else if (run_len != 0) begin last_pulse = run_len; run_len = 0; end
    if (soft_reset && !prev_soft) b_at_rise = bvalid;
    if (wvalid && wready) w_hs++;
    if (bvalid && !prev_b) b_rise++;
    prev_soft = soft_reset;
    prev_b    = bvalid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    m_en = 1'b1; m_done = 1'b0; m_ovr = 1'b0; m_result = '0; m_count = '0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int   t;
    logic aw_ok, w_ok, hs_aw, hs_w;
    aw_ok = 1'b0; w_ok = 1'b0; t = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_ok && w_ok) && t < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick(1); t++;
      if (hs_aw) begin awvalid = 1'b0; aw_ok = 1'b1; end
      if (hs_w)  begin wvalid  = 1'b0; w_ok  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (!bvalid && t < 20) begin tick(1); t++; end
    chk("wr_bvalid_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    tick(1);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int   t;
    logic hs;
    t = 0; hs = 1'b0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!hs && t < 20) begin hs = arready; tick(1); t++; end
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin tick(1); t++; end
    chk("rd_rvalid_timeout", 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    tick(1);
    rready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input string tag);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    ed = '0; er = 2'b00;
    case (a[4:2])
      3'd0:    ed = {31'b0, m_en};
      3'd1:    ed = {29'b0, m_ovr, core_busy, m_done};
      3'd2:    ed = {16'b0, m_result};
      3'd3:    ed = m_count;
      3'd7:    ed = '0;
      default: er = 2'b10;
    endcase
    axi_read(a, d, r);
    if (a[4:2] == 3'd2) begin m_done = 1'b0; m_ovr = 1'b0; end
    chk({tag, "_rdata"}, d, ed);
    chk({tag, "_rresp"}, 32'(r), 32'(er));
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
    logic [1:0] r, er;
    er = (a[4:2] == 3'd4 || a[4:2] == 3'd5 || a[4:2] == 3'd6) ? 2'b10 : 2'b00;
    axi_write(a, d, s, r);
    if (a[4:2] == 3'd0 && s[0]) m_en = d[0];
    if (a[4:2] == 3'd7) begin m_done = 1'b0; m_ovr = 1'b0; m_result = '0; m_count = '0; end
    chk({tag, "_bresp"}, 32'(r), 32'(er));
  endtask

  task automatic strobe(input logic [15:0] v, input bit ignored);
    result_in = v; result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    if (!ignored) begin
      m_ovr = m_ovr | m_done;
      m_done = 1'b1;
      m_result = v;
      m_count++;
    end
  endtask

  task automatic chk_intr(input string tag);
    tick(2);
    chk(tag, 32'(intr), 32'(m_done & m_en));
  endtask

  initial begin
    int          w0, bf, op;
    logic [15:0] old_res;

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; awvalid = 1'b0; wvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    result_in = '0; result_valid = 1'b0; core_busy = 1'b0;
    model_reset();
    #1;
    tick(2);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_soft_reset", 32'(soft_reset), 32'd0);
    rst = 1'b0;
    tick(1);

    do_read(5'h04, "status_after_rst");
    chk("intr_after_rst", 32'(intr), 32'd0);
    do_read(5'h00, "ctrl_after_rst");

    w0 = w_hs;
    do_write(5'h1C, 32'd0, 4'hf, "srst");
    tick(6);
    chk("srst_wready_cycles", 32'(w_hs - w0), 32'd1);
    chk("srst_pulse_len", 32'(last_pulse), 32'd4);
    chk("srst_starts_with_bvalid", 32'(b_at_rise), 32'd1);

    strobe(16'd7, 1'b0);
    chk_intr("intr_after_capture");
    do_read(5'h08, "result7");
    chk_intr("intr_after_result_read");
    do_read(5'h0C, "count1");

    strobe(16'd3, 1'b0);
    tick(1);
    strobe(16'd5, 1'b0);
    do_read(5'h04, "status_overrun");
    do_read(5'h08, "result5");
    do_read(5'h04, "status_cleared");

    do_read(5'h14, "unmapped_rd");
    do_write(5'h10, 32'hdead_beef, 4'hf, "unmapped_wr");
    do_write(5'h08, 32'hffff_ffff, 4'hf, "ro_wr");
    do_read(5'h08, "ro_unchanged");

    // W leads AW by three cycles, then B is back-pressured
    bf = b_rise;
    awaddr = 5'h00; wdata = 32'd0; wstrb = 4'hf; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b0;
    chk("wf_wready", 32'(wready), 32'd1);
    tick(1);
    wvalid = 1'b0;
    chk("wf_wready_latched", 32'(wready), 32'd0);
    tick(2);
    chk("wf_no_early_b", 32'(bvalid), 32'd0);
    awvalid = 1'b1;
    chk("wf_awready", 32'(awready), 32'd1);
    tick(1);
    awvalid = 1'b0;
    for (int t = 0; t < 10 && !bvalid; t++) tick(1);
    chk("wf_bvalid", 32'(bvalid), 32'd1);
    awaddr = 5'h10; awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("wf_bvalid_hold", 32'(bvalid), 32'd1);
      chk("wf_aw_blocked", 32'(awready), 32'd0);
      tick(1);
    end
    awvalid = 1'b0;
    chk("wf_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick(1);
    bready = 1'b0;
    chk("wf_b_done", 32'(bvalid), 32'd0);
    chk("wf_awready_back", 32'(awready), 32'd1);
    chk("wf_single_commit", 32'(b_rise - bf), 32'd1);
    m_en = 1'b0;

    strobe(16'h00aa, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("intr_masked", 32'(intr), 32'd0);
      tick(1);
    end
    core_busy = 1'b1;
    do_read(5'h04, "status_masked_busy");
    core_busy = 1'b0;
    do_read(5'h00, "ctrl_cleared");

    // result_valid during the soft-reset pulse must be dropped
    do_write(5'h00, 32'd1, 4'h1, "ctrl_set");
    strobe(16'h0055, 1'b0);
    do_write(5'h1C, 32'h1234_5678, 4'h0, "srst2");
    chk("pulse_active", 32'(soft_reset), 32'd1);
    strobe(16'h0066, 1'b1);
    tick(5);
    do_read(5'h0C, "count_after_srst");
    do_read(5'h08, "result_after_srst");
    do_read(5'h04, "status_after_srst");
    do_read(5'h00, "ctrl_preserved");

    // Capture in the same cycle as the RESULT read clear
    strobe(16'h0101, 1'b0);
    tick(1);
    strobe(16'h0202, 1'b0);
    old_res = m_result;
    araddr = 5'h08; arvalid = 1'b1; rready = 1'b0; result_in = 16'h1234; result_valid = 1'b1;
    chk("sc_arready", 32'(arready), 32'd1);
    tick(1);
    arvalid = 1'b0; result_valid = 1'b0;
    m_result = 16'h1234; m_done = 1'b1; m_ovr = 1'b0; m_count++;
    chk("sc_rvalid", 32'(rvalid), 32'd1);
    chk("sc_rdata_old", rdata, {16'b0, old_res});
    tick(2);
    chk("sc_rdata_stable", rdata, {16'b0, old_res});
    chk("sc_rvalid_held", 32'(rvalid), 32'd1);
    rready = 1'b1;
    tick(1);
    rready = 1'b0;
    do_read(5'h04, "sc_status");
    do_read(5'h08, "sc_result");
    do_read(5'h0C, "sc_count");

    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 9));
      core_busy = 1'($urandom_range(0, 1));
      if (op <= 3) strobe(16'($urandom), 1'b0);
      else if (op <= 6) do_read(5'($urandom), "rnd_rd");
      else if (op == 7) do_write({3'd0, 2'($urandom)}, $urandom, 4'($urandom), "rnd_ctrl");
      else if (op == 8) do_write({3'($urandom_range(1, 6)), 2'($urandom)}, $urandom, 4'hf, "rnd_ro");
      else begin
        do_write({3'd7, 2'($urandom)}, $urandom, 4'($urandom), "rnd_srst");
        tick(5);
      end
      chk_intr("rnd_intr");
    end
    core_busy = 1'b0;

    // Asynchronous reset while a write is latched but not yet committed
    bf = b_rise;
    awaddr = 5'h00; wdata = 32'd0; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick(1);
    awvalid = 1'b0; wvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_bvalid", 32'(bvalid), 32'd0);
    chk("arst_awready", 32'(awready), 32'd0);
    chk("arst_arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bready = 1'b0;
    model_reset();
    tick(3);
    chk("arst_no_response", 32'(b_rise - bf), 32'd0);
    do_read(5'h00, "arst_ctrl");
    do_read(5'h0C, "arst_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
